// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared types for the timer control scheduler
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_START       = 2'd0,
        OP_CAPTURE     = 2'd1,
        OP_RST_CAPTURE = 2'd2,
        OP_SET_ALARM   = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

endpackage

// File: rtl/timer_ctrl_sched_rr_arbiter.sv
// rtl/timer_ctrl_sched_rr_arbiter.sv - round-robin arbiter, search starts after last winner
module rr_arbiter #(
    parameter  int N  = 10,
    localparam int IW = $clog2(N)
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    logic [IW-1:0] last_q, last_d, idx, win;
    logic [IW:0]   sum;

    // Scan from farthest to nearest so the closest requester after last_q wins.
    always_comb begin
        grant_o = '0;
        win     = last_q;
        idx     = '0;
        sum     = '0;
        for (int k = N; k >= 1; k--) begin
            sum = {1'b0, last_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                win          = idx;
            end
        end
        last_d = (advance_i && |req_i) ? win : last_q;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) last_q <= IW'(N - 1);
        else           last_q <= last_d;
    end

endmodule

// File: rtl/timer_ctrl_sched.sv
// rtl/timer_ctrl_sched.sv - command issue FSM and event/result scheduler for timer instances
module timer_ctrl_sched
    import timer_ctrl_pkg::*;
#(
    parameter  int TIMER_BITWIDTH = 32,
    parameter  int NB_INSTANCES   = 10,
    localparam int IDX_W          = $clog2(NB_INSTANCES)
) (
    input  logic                                   clk,
    input  logic                                   areset_n,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [1:0]                             cmd_op,
    input  logic [IDX_W-1:0]                       cmd_inst,
    input  logic [TIMER_BITWIDTH-1:0]              cmd_data,
    output logic [NB_INSTANCES-1:0]                start_o,
    output logic [NB_INSTANCES-1:0]                capture_o,
    output logic [NB_INSTANCES-1:0]                rst_capture_o,
    output logic [NB_INSTANCES-1:0]                alarm_en_o,
    output logic [TIMER_BITWIDTH-1:0]              alarm_time_o,
    input  logic [NB_INSTANCES-1:0]                cap_valid_i,
    input  logic [NB_INSTANCES*TIMER_BITWIDTH-1:0] cap_value_i,
    input  logic [NB_INSTANCES-1:0]                alarm_i,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [IDX_W-1:0]                       res_inst,
    output logic [TIMER_BITWIDTH-1:0]              res_value,
    output logic                                   res_is_alarm,
    output logic [NB_INSTANCES-1:0]                overrun_o,
    output logic                                   cmd_err
);

    localparam int             N    = NB_INSTANCES;
    localparam int             W    = TIMER_BITWIDTH;
    localparam logic [IDX_W:0] NB_L = (IDX_W+1)'(N);

    state_e           state_q, state_d;
    cmd_op_e          op_q;
    logic [IDX_W-1:0] inst_q, gidx;
    logic [W-1:0]     alarm_time_q, gval;
    logic [W-1:0]     cap_val_q [N];
    logic [N-1:0]     sel, req, grant, grant_cap, grant_alarm;
    logic [N-1:0]     cap_pend_q, cap_pend_d, alarm_pend_q, alarm_pend_d, overrun_q, overrun_d;
    logic             issue, cmd_fire, advance;
    logic             res_valid_q, res_is_alarm_q;
    logic [IDX_W-1:0] res_inst_q;
    logic [W-1:0]     res_value_q;

    assign issue    = (state_q == ST_ISSUE);
    assign cmd_fire = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cmd_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_GUARD;
            ST_GUARD: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Out-of-range instances match no select bit, so they only raise cmd_err.
    always_comb begin
        cmd_ready = areset_n && (state_q == ST_IDLE);
        cmd_err   = issue && !({1'b0, inst_q} < NB_L);
        sel       = '0;
        for (int i = 0; i < N; i++) sel[i] = issue && (inst_q == IDX_W'(i));
        start_o       = sel & {N{op_q == OP_START}};
        capture_o     = sel & {N{op_q == OP_CAPTURE}};
        rst_capture_o = sel & {N{op_q == OP_RST_CAPTURE}};
        alarm_en_o    = sel & {N{op_q == OP_SET_ALARM}};
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            op_q         <= OP_START;
            inst_q       <= '0;
            alarm_time_q <= '0;
        end else if (cmd_fire) begin
            op_q   <= cmd_op_e'(cmd_op);
            inst_q <= cmd_inst;
            if (cmd_op == OP_SET_ALARM) alarm_time_q <= cmd_data;
        end
    end

    assign alarm_time_o = alarm_time_q;

    assign req         = cap_pend_q | alarm_pend_q;
    assign advance     = !res_valid_q || res_ready;
    assign grant_cap   = advance ? (grant & cap_pend_q)  : '0;
    assign grant_alarm = advance ? (grant & ~cap_pend_q) : '0;

    rr_arbiter #(.N(N)) u_arb (
        .clk       (clk),
        .areset_n  (areset_n),
        .req_i     (req),
        .advance_i (advance),
        .grant_o   (grant)
    );

    // New events take priority over grant/reset clears so none is ever dropped.
    assign cap_pend_d   = (cap_pend_q & ~grant_cap & ~rst_capture_o) | cap_valid_i;
    assign alarm_pend_d = (alarm_pend_q & ~grant_alarm & ~rst_capture_o) | alarm_i;
    assign overrun_d    = (overrun_q | (cap_valid_i & cap_pend_q & ~grant_cap)
                                     | (alarm_i & alarm_pend_q & ~grant_alarm)) & ~rst_capture_o;

    always_comb begin
        gidx = '0;
        gval = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i])     gidx = IDX_W'(i);
            if (grant_cap[i]) gval = cap_val_q[i];
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cap_pend_q     <= '0;
            alarm_pend_q   <= '0;
            overrun_q      <= '0;
            res_valid_q    <= 1'b0;
            res_inst_q     <= '0;
            res_value_q    <= '0;
            res_is_alarm_q <= 1'b0;
            for (int i = 0; i < N; i++) cap_val_q[i] <= '0;
        end else begin
            cap_pend_q   <= cap_pend_d;
            alarm_pend_q <= alarm_pend_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < N; i++)
                if (cap_valid_i[i]) cap_val_q[i] <= cap_value_i[i*W +: W];
            if (advance && |req) begin
                res_valid_q    <= 1'b1;
                res_inst_q     <= gidx;
                res_value_q    <= gval;
                res_is_alarm_q <= ~|grant_cap;
            end else if (res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign res_valid    = res_valid_q;
    assign res_inst     = res_inst_q;
    assign res_value    = res_value_q;
    assign res_is_alarm = res_is_alarm_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_timer_ctrl_sched.sv
// tb/tb_timer_ctrl_sched.sv - randomized self-checking bench for timer_ctrl_sched
module tb_timer_ctrl_sched;

    localparam int N  = 10;
    localparam int W  = 32;
    localparam int IW = 4;

    logic           clk = 1'b0, areset_n = 1'b0, cmd_valid = 1'b0, res_ready = 1'b0;
    logic [1:0]     cmd_op = '0;
    logic [IW-1:0]  cmd_inst = '0;
    logic [W-1:0]   cmd_data = '0;
    logic [N-1:0]   cap_valid_i = '0, alarm_i = '0;
    logic [N*W-1:0] cap_value_i = '0;
    logic           cmd_ready, res_valid, res_is_alarm, cmd_err;
    logic [N-1:0]   start_o, capture_o, rst_capture_o, alarm_en_o, overrun_o;
    logic [W-1:0]   alarm_time_o, res_value;
    logic [IW-1:0]  res_inst;

    int n_cmp = 0, n_bad = 0;

    // Reference model: command age (0 idle, 1 strobe cycle, 2 guard), pending sets, result slot.
    int           m_age, m_op, m_inst, m_last, m_res_inst;
    logic [W-1:0] m_atime, m_res_val;
    logic [W-1:0] m_cap_val [N];
    bit   [N-1:0] m_cap_pend, m_al_pend, m_ovr;
    bit           m_res_valid, m_res_alarm;

    timer_ctrl_sched #(.TIMER_BITWIDTH(W), .NB_INSTANCES(N)) dut (
        .clk(clk), .areset_n(areset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_inst(cmd_inst), .cmd_data(cmd_data),
        .start_o(start_o), .capture_o(capture_o), .rst_capture_o(rst_capture_o),
        .alarm_en_o(alarm_en_o), .alarm_time_o(alarm_time_o),
        .cap_valid_i(cap_valid_i), .cap_value_i(cap_value_i), .alarm_i(alarm_i),
        .res_valid(res_valid), .res_ready(res_ready), .res_inst(res_inst),
        .res_value(res_value), .res_is_alarm(res_is_alarm),
        .overrun_o(overrun_o), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_op = 0; m_inst = 0; m_last = N - 1; m_atime = '0;
        m_cap_pend = '0; m_al_pend = '0; m_ovr = '0;
        m_res_valid = 0; m_res_alarm = 0; m_res_inst = 0; m_res_val = '0;
        for (int i = 0; i < N; i++) m_cap_val[i] = '0;
    endtask

    function automatic logic [N-1:0] m_strobe(input int op);
        m_strobe = '0;
        if (m_age == 1 && m_op == op && m_inst < N) m_strobe[m_inst] = 1'b1;
    endfunction

    task automatic model_step();
        int g, ri, j;
        bit gcap;
        g  = -1;
        ri = (m_age == 1 && m_op == 2 && m_inst < N) ? m_inst : -1;
        if (!m_res_valid || res_ready) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (g < 0 && (m_cap_pend[j] || m_al_pend[j])) g = j;
            end
            if (g >= 0) begin
                gcap = m_cap_pend[g];
                m_res_valid = 1; m_res_inst = g; m_res_alarm = !gcap;
                m_res_val = gcap ? m_cap_val[g] : '0;
                m_last = g;
                if (gcap) m_cap_pend[g] = 0; else m_al_pend[g] = 0;
            end else m_res_valid = 0;
        end
        if (ri >= 0) begin m_cap_pend[ri] = 0; m_al_pend[ri] = 0; m_ovr[ri] = 0; end
        for (int i = 0; i < N; i++) begin
            if (cap_valid_i[i]) begin
                if (m_cap_pend[i]) m_ovr[i] = 1;
                m_cap_pend[i] = 1;
                m_cap_val[i]  = cap_value_i[i*W +: W];
            end
            if (alarm_i[i]) begin
                if (m_al_pend[i]) m_ovr[i] = 1;
                m_al_pend[i] = 1;
            end
        end
        if (m_age == 0) begin
            if (cmd_valid) begin
                m_op = int'(cmd_op); m_inst = int'(cmd_inst); m_age = 1;
                if (cmd_op == 2'd3) m_atime = cmd_data;
            end
        end else m_age = (m_age + 1) % 3;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (areset_n) model_step();
        #2;
        cmd_valid = 1'b0; cap_valid_i = '0; alarm_i = '0;
    endtask

    task automatic send(input int op, input int inst, input logic [W-1:0] data);
        for (int b = 0; b < 4 && m_age != 0; b++) cyc();
        cmd_op = 2'(op); cmd_inst = IW'(inst); cmd_data = data; cmd_valid = 1'b1;
        cyc();
    endtask

    task automatic cap(input int i, input logic [W-1:0] v);
        cap_valid_i[i] = 1'b1;
        cap_value_i[i*W +: W] = v;
    endtask

    always @(negedge clk) begin
        chk("cmd_ready", 64'(cmd_ready), 64'(areset_n && m_age == 0));
        chk("start_o", 64'(start_o), 64'(m_strobe(0)));
        chk("capture_o", 64'(capture_o), 64'(m_strobe(1)));
        chk("rst_capture_o", 64'(rst_capture_o), 64'(m_strobe(2)));
        chk("alarm_en_o", 64'(alarm_en_o), 64'(m_strobe(3)));
        chk("alarm_time_o", 64'(alarm_time_o), 64'(m_atime));
        chk("cmd_err", 64'(cmd_err), 64'(m_age == 1 && m_inst >= N));
        chk("overrun_o", 64'(overrun_o), 64'(m_ovr));
        chk("res_valid", 64'(res_valid), 64'(m_res_valid));
        chk("res_inst", 64'(res_inst), 64'(m_res_inst));
        chk("res_value", 64'(res_value), 64'(m_res_val));
        chk("res_is_alarm", 64'(res_is_alarm), 64'(m_res_alarm));
    end

    initial begin
        model_reset();
        repeat (2) cyc();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_alarm_time", 64'(alarm_time_o), 64'd0);
        areset_n = 1'b1;
        #1 chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        send(0, 3, '0);
        chk("start3", 64'(start_o), 64'h008);
        chk("start3_rdy1", 64'(cmd_ready), 64'd0);
        cyc();
        chk("start3_off", 64'(start_o), 64'h000);
        chk("start3_rdy2", 64'(cmd_ready), 64'd0);
        cyc();
        chk("start3_rdy3", 64'(cmd_ready), 64'd1);

        send(3, 9, 32'd1000);
        chk("alarm9_en", 64'(alarm_en_o), 64'h200);
        chk("alarm9_time", 64'(alarm_time_o), 64'd1000);
        cyc();
        chk("alarm9_en_off", 64'(alarm_en_o), 64'h000);
        res_ready = 1'b1; alarm_i[9] = 1'b1;
        cyc(); cyc();
        chk("alarm9_res_inst", 64'(res_inst), 64'd9);
        chk("alarm9_res_isal", 64'(res_is_alarm), 64'd1);
        chk("alarm9_res_val", 64'(res_value), 64'd0);
        cyc();

        cap(0, 32'd100); cap(4, 32'd104); cap(7, 32'd107);
        cyc(); cyc();
        chk("burst1_a", 64'(res_inst), 64'd0);
        chk("burst1_a_val", 64'(res_value), 64'd100);
        cyc(); chk("burst1_b", 64'(res_inst), 64'd4);
        cyc(); chk("burst1_c", 64'(res_inst), 64'd7);
        cap(2, 32'd22); cap(8, 32'd28);
        cyc(); cyc(); chk("burst2_a", 64'(res_inst), 64'd8);
        cyc(); chk("burst2_b", 64'(res_inst), 64'd2);
        cyc(); chk("burst2_idle", 64'(res_valid), 64'd0);

        res_ready = 1'b0; cap(5, 32'd7);
        cyc(); cyc(); chk("stall_inst", 64'(res_inst), 64'd5);
        cap(2, 32'd50); cyc();
        cap(2, 32'd100); cyc();
        chk("ovr2_set", 64'(overrun_o), 64'h004);
        res_ready = 1'b1;
        cyc();
        chk("ovr2_res_inst", 64'(res_inst), 64'd2);
        chk("ovr2_res_val", 64'(res_value), 64'd100);
        cyc(); chk("ovr2_single", 64'(res_valid), 64'd0);
        send(2, 2, '0); cyc();
        chk("ovr2_clr", 64'(overrun_o), 64'h000);

        send(0, 12, '0);
        chk("bad_inst_err", 64'(cmd_err), 64'd1);
        chk("bad_inst_strb", 64'(start_o | capture_o | rst_capture_o | alarm_en_o), 64'd0);
        cyc(); chk("bad_inst_err_off", 64'(cmd_err), 64'd0);

        res_ready = 1'b0; cap(1, 32'd11); cap(3, 32'd33);
        cyc(); cyc();
        send(0, 6, '0);
        chk("pre_rst_start6", 64'(start_o), 64'h040);
        areset_n = 1'b0; model_reset();
        #1;
        chk("rst_start", 64'(start_o), 64'd0);
        chk("rst_res_valid2", 64'(res_valid), 64'd0);
        chk("rst_res_inst", 64'(res_inst), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        cyc(); cyc();
        areset_n = 1'b1; res_ready = 1'b1;
        repeat (4) begin
            cyc();
            chk("post_rst_res", 64'(res_valid), 64'd0);
            chk("post_rst_start", 64'(start_o), 64'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_inst  = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(10, 15)) : IW'($urandom_range(0, 9));
            cmd_data  = $urandom;
            for (int i = 0; i < N; i++) begin
                cap_valid_i[i] = ($urandom_range(0, 15) == 0);
                alarm_i[i]     = ($urandom_range(0, 19) == 0);
                cap_value_i[i*W +: W] = $urandom;
            end
            res_ready = ($urandom_range(0, 9) < (((c / 250) % 2 == 1) ? 2 : 9));
            if (c % 700 == 350) begin
                areset_n = 1'b0; model_reset();
                cyc(); cyc();
                areset_n = 1'b1;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
